pwm_ramp: RTL and testbench

- Upstream stage of the PWM generator: produces its `level` input.
- Accepts a target duty level and step size over a valid/ready handshake.
- Moves `level` toward the target in saturating steps, only at PWM-period boundaries, so the PWM never sees a mid-period duty change.
- Used for LED fades and soft-start of motor/heater drives.

---
 rtl/pwm_ramp.sv | 148 ++++++++++++++
 tb/tb_pwm_ramp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp.sv
// pwm_ramp: ramps the PWM duty `level` toward a requested target in saturating
// steps, applying each change only at a PWM period boundary (update tick).
// Optional build macro: PWM_RAMP_RETARGET_EN -- when defined, new targets are
// also accepted while a ramp is in progress and replace the running ramp.
module pwm_ramp #(
    parameter int unsigned N     = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [N-1:0]     tgt_level,
    input  logic [N-1:0]     tgt_step,
    input  logic [DIV_W-1:0] div,
    output logic [N-1:0]     level,
    output logic             busy,
    output logic             done,
    output logic             frame
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [N-1:0] FRAME_LAST = '1;

    logic [1:0]       state,     state_n;
    logic [N-1:0]     frame_cnt, frame_cnt_n;
    logic [DIV_W-1:0] div_cnt,   div_cnt_n;
    logic [N-1:0]     tgt_q,     tgt_n;
    logic [N-1:0]     step_q,    step_n;
    logic [N-1:0]     level_n;
    logic             busy_n;
    logic             done_n;
    logic             frame_n;

    logic             accept;
    logic             tick;
    logic [N-1:0]     step_in;
    logic [N:0]       up_sum;
    logic [N:0]       dn_diff;
    logic [N-1:0]     up_lvl;
    logic [N-1:0]     dn_lvl;

    // Ready is a decode of the state register, forced low while reset is held
`ifdef PWM_RAMP_RETARGET_EN
    assign tgt_ready = ~reset;
`else
    assign tgt_ready = ~reset & (state == ST_IDLE);
`endif

    assign accept  = tgt_valid & tgt_ready;
    assign tick    = frame & (div_cnt == div);
    assign step_in = (tgt_step == '0) ? N'(1) : tgt_step;

    // Saturating step arithmetic carried in N+1 bits so nothing wraps
    assign up_sum  = {1'b0, level} + {1'b0, step_q};
    assign dn_diff = {1'b0, level} - {1'b0, step_q};
    assign up_lvl  = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[N-1:0];
    assign dn_lvl  = (dn_diff[N] || (dn_diff[N-1:0] < tgt_q)) ? tgt_q : dn_diff[N-1:0];

    // Next-state, frame/divider counters and registered output values
    always_comb begin
        state_n     = state;
        level_n     = level;
        tgt_n       = tgt_q;
        step_n      = step_q;
        done_n      = 1'b0;
        frame_cnt_n = frame_cnt + N'(1);
        frame_n     = (frame_cnt_n == FRAME_LAST);
        div_cnt_n   = div_cnt;

        if (frame) begin
            div_cnt_n = tick ? '0 : div_cnt + DIV_W'(1);
        end

        if (accept) begin
            // Acceptance restarts the update cadence and picks a direction
            div_cnt_n = '0;
            tgt_n     = tgt_level;
            step_n    = step_in;
            if (tgt_level == level) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end else if (tgt_level > level) begin
                state_n = ST_UP;
            end else begin
                state_n = ST_DOWN;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_UP: begin
                    if (tick) begin
                        level_n = up_lvl;
                        if (up_lvl == tgt_q) begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (tick) begin
                        level_n = dn_lvl;
                        if (dn_lvl == tgt_q) begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers; synchronous reset dominates everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            div_cnt   <= '0;
            tgt_q     <= '0;
            step_q    <= '0;
            level     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame     <= 1'b0;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
            div_cnt   <= div_cnt_n;
            tgt_q     <= tgt_n;
            step_q    <= step_n;
            level     <= level_n;
            busy      <= busy_n;
            done      <= done_n;
            frame     <= frame_n;
        end
    end

endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp: scoreboard bench for pwm_ramp. Each accepted target is turned
// into a list of expected (cycle, level, done) events from the ramp rules;
// a monitor pops and compares whenever level changes or done pulses.
module tb_pwm_ramp;

    localparam int PERIOD = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [7:0] tgt_level = '0;
    logic [7:0] tgt_step = '0;
    logic [7:0] div = '0;
    logic [7:0] level;
    logic       busy;
    logic       done;
    logic       frame;

    pwm_ramp #(.N(8), .DIV_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_level (tgt_level),
        .tgt_step  (tgt_step),
        .div       (div),
        .level     (level),
        .busy      (busy),
        .done      (done),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int lvl;
        bit dn;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  cur_level = 0;
    int  prev_level = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected event list for one accepted target, from the ramp rules
    function automatic void push_ramp(int ta, int start, int tl, int ts, int d);
        int s, fc, lv, j;
        ev_t ev;
        s = (ts == 0) ? 1 : ts;
        if (tl == start) begin
            ev.cyc = ta + 1; ev.lvl = start; ev.dn = 1'b1;
            q.push_back(ev);
            return;
        end
        fc = (ta / PERIOD) * PERIOD + PERIOD - 1;
        if (fc <= ta) fc += PERIOD;
        lv = start;
        j  = 1;
        while (lv != tl) begin
            if (tl > start) lv = (lv + s > tl) ? tl : lv + s;
            else            lv = (lv - s < tl) ? tl : lv - s;
            ev.cyc = fc + ((d + 1) * j - 1) * PERIOD + 1;
            ev.lvl = lv;
            ev.dn  = (lv == tl);
            q.push_back(ev);
            j++;
        end
    endfunction

    // Cycle index since reset release; equals the frame phase mod PERIOD
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Monitor: frame cadence every cycle, level/done events against the queue
    always @(negedge clk) begin
        if (reset) begin
            check("ready_in_reset", int'(tgt_ready), 0);
            prev_level = 0;
        end else begin
            check("frame", int'(frame), int'(cyc % PERIOD == PERIOD - 1));
            if (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event_cycle", cyc, q[0].cyc);
                cur_level = q[0].lvl;
                void'(q.pop_front());
            end
            if (int'(level) != prev_level || done) begin
                if (q.size() == 0) begin
                    check("unexpected_event_level", int'(level), prev_level);
                    check("unexpected_event_done", int'(done), 0);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("level", int'(level), e.lvl);
                    check("done", int'(done), int'(e.dn));
                    check("busy", int'(busy), int'(!e.dn));
                    cur_level = e.lvl;
                end
            end
            prev_level = int'(level);
        end
    end

    task automatic send(input int tl, input int ts, input int d, output int ta);
        int waited;
        int start;
        waited = 0;
        @(posedge clk); #1;
        div       = 8'(d);
        tgt_level = 8'(tl);
        tgt_step  = 8'(ts);
        tgt_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (tgt_ready) break;
            waited++;
            if (waited > 20000) begin
                check("accept_timeout", waited, 0);
                tgt_valid = 1'b0;
                ta = -1;
                return;
            end
        end
        ta = cyc;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
`ifndef PWM_RAMP_RETARGET_EN
        check("queue_empty_at_accept", q.size(), 0);
`endif
        q.delete();
        start = cur_level;
        push_ramp(ta, start, tl, ts, d);
        @(negedge clk);
        check("busy_after_accept", int'(busy), int'(tl != start));
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > bound) begin
                check("ramp_timeout", n, bound);
                q.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_level(input int v, input int bound);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (int'(level) == v) break;
            n++;
            if (n > bound) begin
                check("wait_level_timeout", int'(level), v);
                break;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset     = 1'b1;
        tgt_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        cur_level = 0;
        @(negedge clk);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(tgt_ready), 1);
    endtask

    // Global time bound
    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta;
        int exp_ta;

        do_reset(3);
        repeat (600) @(posedge clk);

        send(40, 16, 0, ta);   wait_idle(2000);
        send(0, 30, 1, ta);    wait_idle(3000);
        send(250, 200, 0, ta); wait_idle(2000);
        send(250, 200, 0, ta); wait_idle(20);

        // Reset in the middle of a ramp toward 100
        send(0, 255, 0, ta);   wait_idle(2000);
        send(100, 16, 0, ta);
        wait_level(32, 2000);
        do_reset(1);
        repeat (600) @(posedge clk);

        // Retarget while ramping up toward 200
        send(200, 32, 0, ta);
        wait_level(64, 2000);
`ifdef PWM_RAMP_RETARGET_EN
        exp_ta = cyc + 1;
`else
        exp_ta = (q.size() > 0) ? q[$].cyc : -1;
`endif
        send(10, 20, 0, ta);
        check("retarget_accept_cycle", ta, exp_ta);
        wait_idle(6000);

        // Step 0 behaves as step 1
        send(cur_level + 3, 0, 0, ta); wait_idle(2000);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 300)) @(posedge clk);
            send(int'($urandom_range(0, 255)), int'($urandom_range(40, 255)),
                 int'($urandom_range(0, 1)), ta);
            wait_idle(6000);
        end

        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
